alu_cmd_sequencer: RTL

Initiator-side controller for the 16-bit ALU (Ain, Bin, ALUop -> out, Z). Accepts one operation at a time over a valid/ready command port and drives registered operands and opcode into the ALU. Captures out/Z after one settle cycle and returns them over a valid/ready result port. Sits between the datapath FSM or host and the ALU; the ALU stays purely combinational.

---
 rtl/alu_cmd_sequencer.sv | 108 ++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: one-at-a-time command/result sequencer for a combinational 16-bit ALU.
// Ports: clk, reset (async high); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b command port;
//   alu_ain/alu_bin/alu_op drive the ALU, alu_out/alu_z are captured after one settle cycle;
//   res_valid/res_ready/res_data/res_z/res_err result port; err_sticky; op_count.
// Optional: define ALU_SEQ_SELFCHECK_EN to check ALU results against a local reference.
module alu_cmd_sequencer #(
    parameter int DATA_W  = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [DATA_W-1:0]  cmd_a,
    input  logic [DATA_W-1:0]  cmd_b,
    output logic [DATA_W-1:0]  alu_ain,
    output logic [DATA_W-1:0]  alu_bin,
    output logic [1:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_data,
    output logic               res_z,
    output logic               res_err,
    output logic               err_sticky,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;

    // Handshake outputs decode from state only, so no input reaches an output.
    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            alu_ain  <= '0;
            alu_bin  <= '0;
            alu_op   <= 2'b00;
            res_data <= '0;
            res_z    <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_ain <= cmd_a;
                        alu_bin <= cmd_b;
                        alu_op  <= cmd_op;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU inputs have been stable for this whole cycle.
                    res_data <= alu_out;
                    res_z    <= alu_z;
                    state    <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        op_count <= op_count + COUNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_SELFCHECK_EN
    logic [DATA_W-1:0] exp_data;
    logic              mismatch;

    always_comb begin
        exp_data = '0;
        case (alu_op)
            2'b00:   exp_data = alu_ain + alu_bin;
            2'b01:   exp_data = alu_ain - alu_bin;
            2'b10:   exp_data = alu_ain & alu_bin;
            default: exp_data = ~alu_bin;
        endcase
        mismatch = (alu_out != exp_data) || (alu_z != (exp_data == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_err    <= 1'b0;
            err_sticky <= 1'b0;
        end else if (state == EXEC) begin
            res_err <= mismatch;
            if (mismatch) begin
                err_sticky <= 1'b1;
            end
        end
    end
`else
    assign res_err    = 1'b0;
    assign err_sticky = 1'b0;
`endif

endmodule
